// File: rtl/burst_mem_mc_pkg.sv
// burst_mem_pkg: shared types and helpers for the multi-channel
// burst memory controller.
package burst_mem_pkg;

  localparam int ADDRLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_e;

  typedef enum logic {
    RD,
    WR
  } op_e;

  typedef logic [ADDRLEN-1:0] page_t;
  typedef logic [7:0]         bank_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/burst_mem_mc_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; search starts one past
// the most recent winner.
module rr_arbiter
  import burst_mem_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               req,
  input  logic                       advance,
  output logic [N-1:0]               grant,
  output logic [clog2_min1(N)-1:0]   grant_idx
);

  localparam int IW = clog2_min1(N);

  logic [IW-1:0] ptr;
  logic          found;
  int            j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      if (int'(grant_idx) == N - 1) ptr <= '0;
      else                          ptr <= grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/burst_mem_mc.sv
// burst_mem_mc: NUM_CH requesters share one line store; round-robin
// grant, per-bank open-page latency, BURST_LEN beats per line.
module burst_mem_mc
  import burst_mem_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int DELAY_MEM        = 10,
  parameter int DELAY_PAGE_HIT   = 3,
  parameter int BURST_LEN        = 4,
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int PAGE_SIZE        = 1024,
  parameter int NUM_BANKS        = 4,
  parameter int DEPTH_LINES      = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_CH-1:0] ch_read,
  input  logic [NUM_CH-1:0] ch_write,
  input  logic [NUM_CH*ADDRLEN-1:0] ch_addr,
  input  logic [NUM_CH*(CACHE_LINE_WIDTH/BURST_LEN)-1:0] ch_wdata,
  output logic [CACHE_LINE_WIDTH/BURST_LEN-1:0] rdata,
  output logic [NUM_CH-1:0] ch_resp,
  output logic [NUM_CH-1:0] ch_error
);

  localparam int BW   = CACHE_LINE_WIDTH / BURST_LEN;
  localparam int OFS  = $clog2(CACHE_LINE_WIDTH / 8);
  localparam int LW   = $clog2(DEPTH_LINES);
  localparam int PGB  = $clog2(PAGE_SIZE);
  localparam int BKW  = clog2_min1(NUM_BANKS);
  localparam int CW   = clog2_min1(NUM_CH);
  localparam int BTW  = clog2_min1(BURST_LEN);
  localparam int DMAX = (DELAY_MEM > DELAY_PAGE_HIT) ?
                        DELAY_MEM : DELAY_PAGE_HIT;
  localparam int DW   = $clog2(DMAX + 1);

  logic [CACHE_LINE_WIDTH-1:0] mem [DEPTH_LINES];

  state_e            state;
  op_e               op_q;
  logic [CW-1:0]     gnt_q;
  logic [ADDRLEN-1:0] addr_q;
  logic [DW-1:0]     cnt;
  logic [BTW-1:0]    beat;
  logic [NUM_CH-1:0] resp_q;
  logic [NUM_CH-1:0] err_q;
  logic [BW-1:0]     rdata_q;
  logic [NUM_BANKS-1:0] pg_vld;
  page_t             pg_num [NUM_BANKS];

  logic [NUM_CH-1:0] both;
  logic [NUM_CH-1:0] req;
  logic              arb_adv;
  logic [NUM_CH-1:0] gnt_oh;
  logic [CW-1:0]     gnt_idx;

  logic [ADDRLEN-1:0] new_addr;
  page_t             new_page;
  logic [BKW-1:0]    new_bank;
  logic              page_hit;
  op_e               new_op;

  logic              g_rd;
  logic              g_wr;
  logic [ADDRLEN-1:0] g_addr;
  logic              viol;
  logic [LW-1:0]     line_q;
  logic [BTW-1:0]    nbeat;
  logic [NUM_CH-1:0] g_oh;
  logic              mem_we;
  logic [BW-1:0]     wbeat;

  // A channel asking for both ops at once is rejected, not arbitrated.
  assign both    = ch_read & ch_write;
  assign req     = (ch_read | ch_write) & ~both;
  assign arb_adv = (state == IDLE) && (|req);

  rr_arbiter #(
    .N(NUM_CH)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .advance  (arb_adv),
    .grant    (gnt_oh),
    .grant_idx(gnt_idx)
  );

  assign new_addr = ch_addr[ADDRLEN*gnt_idx +: ADDRLEN];
  assign new_page = new_addr >> PGB;
  assign new_bank = BKW'(new_page % NUM_BANKS);
  assign page_hit = pg_vld[new_bank] && (pg_num[new_bank] == new_page);
  assign new_op   = ch_write[gnt_idx] ? WR : RD;

  assign g_rd   = ch_read[gnt_q];
  assign g_wr   = ch_write[gnt_q];
  assign g_addr = ch_addr[ADDRLEN*gnt_q +: ADDRLEN];
  assign g_oh   = NUM_CH'(1) << gnt_q;
  assign line_q = addr_q[OFS +: LW];
  assign nbeat  = beat + 1'b1;
  assign wbeat  = ch_wdata[BW*gnt_q +: BW];

  always_comb begin
    viol = (g_addr != addr_q);
    unique case (op_q)
      RD: viol = viol | !g_rd | g_wr;
      WR: viol = viol | !g_wr | g_rd;
      default: viol = 1'b1;
    endcase
  end

  assign mem_we = rst && (state == BURST) && (op_q == WR) && !viol;

  always_ff @(posedge clk) begin
    if (mem_we) mem[line_q][BW*beat +: BW] <= wbeat;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      op_q    <= RD;
      gnt_q   <= '0;
      addr_q  <= '0;
      cnt     <= '0;
      beat    <= '0;
      resp_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      pg_vld  <= '0;
    end else begin
      err_q <= '0;
      unique case (state)
        IDLE: begin
          if (arb_adv) begin
            gnt_q  <= gnt_idx;
            addr_q <= new_addr;
            op_q   <= new_op;
            cnt    <= page_hit ? DW'(DELAY_PAGE_HIT - 1)
                               : DW'(DELAY_MEM - 1);
            pg_vld[new_bank] <= 1'b1;
            pg_num[new_bank] <= new_page;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (viol) begin
            err_q <= g_oh;
            state <= IDLE;
          end else if (cnt == '0) begin
            beat   <= '0;
            resp_q <= g_oh;
            if (op_q == RD) rdata_q <= mem[line_q][BW-1:0];
            state  <= BURST;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BURST: begin
          if (viol) begin
            err_q  <= g_oh;
            resp_q <= '0;
            state  <= IDLE;
          end else if (beat == BTW'(BURST_LEN - 1)) begin
            resp_q <= '0;
            state  <= IDLE;
          end else begin
            beat <= nbeat;
            if (op_q == RD) rdata_q <= mem[line_q][BW*nbeat +: BW];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rdata    = rdata_q;
  assign ch_resp  = resp_q;
  assign ch_error = err_q | ((state == IDLE) ? both : '0);

endmodule

// File: tb/tb_burst_mem_mc.sv
// tb_burst_mem_mc: directed stimulus feeding a beat/error scoreboard
// drained by an independent negedge monitor.
module tb_burst_mem_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ch_read;
  logic [1:0]  ch_write;
  logic [63:0] ch_addr;
  logic [127:0] ch_wdata;
  logic [63:0] rdata;
  logic [1:0]  ch_resp;
  logic [1:0]  ch_error;

  burst_mem_mc dut (
    .clk     (clk),
    .rst     (rst),
    .ch_read (ch_read),
    .ch_write(ch_write),
    .ch_addr (ch_addr),
    .ch_wdata(ch_wdata),
    .rdata   (rdata),
    .ch_resp (ch_resp),
    .ch_error(ch_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    int          cyc;
    bit          wr;
    logic [63:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t err_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  logic [63:0] model [256][4];

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void push_beat(int ch, int c, bit wr,
                                    logic [63:0] d);
    ev_t e;
    e.ch = ch; e.cyc = c; e.wr = wr; e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void push_err(int ch, int c);
    ev_t e;
    e.ch = ch; e.cyc = c; e.wr = 1'b0; e.data = '0;
    err_q.push_back(e);
  endfunction

  function automatic int line_of(logic [31:0] a);
    return int'((a >> 5) & 32'hFF);
  endfunction

  always @(negedge clk) begin : mon
    ev_t e;
    if (ch_resp != 2'b00) begin
      chk("resp_onehot", 64'($countones(ch_resp)), 64'd1);
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 64'(ch_resp), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_ch", 64'(ch_resp), 64'(2'b01 << e.ch));
        chk("resp_cyc", 64'(cyc), 64'(e.cyc));
        if (!e.wr) chk("rdata", rdata, e.data);
      end
    end
    if (ch_error != 2'b00) begin
      if (err_q.size() == 0) begin
        chk("err_unexpected", 64'(ch_error), 64'd0);
      end else begin
        e = err_q.pop_front();
        chk("err_ch", 64'(ch_error), 64'(2'b01 << e.ch));
        chk("err_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic go(input int c);
    repeat (c - cyc) @(posedge clk);
    #1;
  endtask

  task automatic clr(input int ch);
    ch_read[ch]  = 1'b0;
    ch_write[ch] = 1'b0;
  endtask

  // drop_beat: beat on which the op is released; move_at: WAIT offset
  // at which the address is changed (-1 disables either).
  task automatic txn(input int ch, input bit wr, input logic [31:0] addr,
                     input int d, input logic [63:0] wd [4],
                     input int drop_beat, input int move_at);
    int t;
    int c;
    int ln;
    t  = cyc;
    ln = line_of(addr);
    ch_addr[32*ch +: 32] = addr;
    ch_read[ch]  = !wr;
    ch_write[ch] = wr;
    if (move_at >= 0) begin
      push_err(ch, t + move_at + 1);
      go(t + move_at);
      ch_addr[32*ch +: 32] = addr ^ 32'h20;
      go(t + move_at + 1);
      clr(ch);
      return;
    end
    for (int i = 0; i < 4; i++) begin
      c = t + 1 + d + i;
      go(c);
      if (i == drop_beat) begin
        clr(ch);
        push_beat(ch, c, wr, '0);
        push_err(ch, c + 1);
        go(c + 1);
        return;
      end
      if (wr) begin
        ch_wdata[64*ch +: 64] = wd[i];
        model[ln][i] = wd[i];
      end
      push_beat(ch, c, wr, wr ? 64'd0 : model[ln][i]);
    end
    go(t + d + 5);
    clr(ch);
  endtask

  logic [63:0] wd [4];
  logic [63:0] nd [4];
  int t;

  initial begin
    rst = 1'b0;
    ch_read = '0;
    ch_write = '0;
    ch_addr = '0;
    ch_wdata = '0;
    nd = '{64'd0, 64'd0, 64'd0, 64'd0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", rdata, 64'd0);
    chk("reset_resp", 64'(ch_resp), 64'd0);
    chk("reset_error", 64'(ch_error), 64'd0);
    rst = 1'b1;
    go(cyc + 1);

    // write miss, then read back on the now-open page
    wd = '{64'hA, 64'hB, 64'hC, 64'hD};
    txn(0, 1'b1, 32'h100, 10, wd, -1, -1);
    txn(0, 1'b0, 32'h100, 3, nd, -1, -1);

    // page hit on the same page, then a new page in bank 0
    wd = '{64'h11, 64'h12, 64'h13, 64'h14};
    txn(0, 1'b1, 32'h140, 3, wd, -1, -1);
    txn(0, 1'b0, 32'h140, 3, nd, -1, -1);
    wd = '{64'h51, 64'h52, 64'h53, 64'h54};
    txn(0, 1'b1, 32'h1100, 10, wd, -1, -1);
    txn(0, 1'b0, 32'h1100, 3, nd, -1, -1);
    txn(0, 1'b0, 32'h100, 10, nd, -1, -1);

    // two channels contending; last winner was ch0 so ch1 leads
    t = cyc;
    ch_addr[31:0]  = 32'h100;
    ch_addr[63:32] = 32'h140;
    for (int r = 0; r < 2; r++) begin
      if (r > 0) go(t + 16 * r);
      ch_read = 2'b11;
      for (int i = 0; i < 4; i++)
        push_beat(1, t + 16 * r + 4 + i, 1'b0, model[10][i]);
      for (int i = 0; i < 4; i++)
        push_beat(0, t + 16 * r + 12 + i, 1'b0, model[8][i]);
      go(t + 16 * r + 8);
      ch_read[1] = 1'b0;
    end
    go(t + 32);
    ch_read = '0;

    // address moved during WAIT, then write dropped on beat 2
    txn(1, 1'b0, 32'h140, 3, nd, -1, 2);
    wd = '{64'h21, 64'h22, 64'h23, 64'h24};
    txn(0, 1'b1, 32'h100, 3, wd, 2, -1);
    txn(0, 1'b0, 32'h100, 3, nd, -1, -1);

    // reset in the middle of a read burst
    t = cyc;
    ch_addr[31:0] = 32'h100;
    ch_read[0] = 1'b1;
    push_beat(0, t + 4, 1'b0, model[8][0]);
    push_beat(0, t + 5, 1'b0, model[8][1]);
    go(t + 5);
    rst = 1'b0;
    go(t + 6);
    rst = 1'b1;
    ch_read = '0;
    chk("rst_mid_rdata", rdata, 64'd0);
    chk("rst_mid_resp", 64'(ch_resp), 64'd0);
    chk("rst_mid_error", 64'(ch_error), 64'd0);
    go(t + 7);
    txn(0, 1'b0, 32'h100, 10, nd, -1, -1);

    // line wrap-around and read+write conflict
    wd = '{64'h31, 64'h32, 64'h33, 64'h34};
    txn(0, 1'b1, 32'h0, 3, wd, -1, -1);
    txn(0, 1'b0, 32'h2000, 10, nd, -1, -1);
    t = cyc;
    ch_addr[63:32] = 32'h40;
    ch_read[1] = 1'b1;
    ch_write[1] = 1'b1;
    push_err(1, t);
    go(t + 1);
    clr(1);
    go(t + 16);

    chk("beats_outstanding", 64'(exp_q.size()), 64'd0);
    chk("errors_outstanding", 64'(err_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
